// File: rtl/mem_replay_rd_scheduler.sv
// mem_replay_rd_scheduler
// Issues QDR read bursts over an inclusive address window [low, high] for the
// pcap replay engine. Each sweep is counted, and the engine stops after a
// programmed number of sweeps or on a stop pulse. Reads are only issued while
// the downstream packet FIFO has credit for the returning words, so that FIFO
// can never overflow.
module mem_replay_rd_scheduler #(
  parameter int unsigned MEM_ADDR_WIDTH   = 19,
  parameter int unsigned MEM_BURST_LENGTH = 2,
  parameter int unsigned FIFO_DEPTH       = 64,
  parameter int unsigned ITER_WIDTH       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sw_rst,
  input  logic                      cal_done,
  input  logic                      cfg_start,
  input  logic                      cfg_stop,
  input  logic [MEM_ADDR_WIDTH-1:0] cfg_addr_low,
  input  logic [MEM_ADDR_WIDTH-1:0] cfg_addr_high,
  input  logic [ITER_WIDTH-1:0]     cfg_iterations,
  input  logic                      mem_rd_full,
  output logic                      mem_r_n,
  output logic [MEM_ADDR_WIDTH-1:0] mem_ad_rd,
  input  logic                      fifo_rd_en,
  output logic                      status_busy,
  output logic                      status_done,
  output logic                      status_err,
  output logic [ITER_WIDTH-1:0]     status_iter_cnt
);

  // FIFO words returned per read command
  localparam int unsigned WPR = MEM_BURST_LENGTH / 2;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0]             CRED_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]             CRED_WPR  = CW'(WPR);
  localparam logic [CW-1:0]             CRED_ONE  = CW'(1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_STEP = MEM_ADDR_WIDTH'(WPR);
  localparam logic [ITER_WIDTH-1:0]     ITER_ONE  = ITER_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CAL,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [MEM_ADDR_WIDTH-1:0] addr_low_q,  addr_low_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_high_q, addr_high_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_cur_q,  addr_cur_d;
  logic [ITER_WIDTH-1:0]     iter_tgt_q,  iter_tgt_d;
  logic [ITER_WIDTH-1:0]     iter_cnt_q,  iter_cnt_d;
  logic [CW-1:0]             credits_q,   credits_d;
  logic                      err_q,       err_d;
  logic                      mem_r_n_q,   mem_r_n_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_ad_q,    mem_ad_d;
  logic                      busy_q,      busy_d;
  logic                      done_q,      done_d;

  logic                      reset_any;
  logic                      start_ok;
  logic                      cfg_bad;
  logic                      bl_gap_ok;
  logic                      issue_ok;
  logic                      at_high;
  logic [ITER_WIDTH-1:0]     iter_inc;
  logic                      final_wrap;

  assign reset_any = rst | sw_rst;
  assign start_ok  = cfg_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign cfg_bad   = (cfg_addr_high < cfg_addr_low);

  // BL4 bursts occupy the read port for two cycles: a read the previous
  // cycle shows up as mem_r_n_q low, which blocks this cycle.
  assign bl_gap_ok = (MEM_BURST_LENGTH != 4) || mem_r_n_q;

  // A stop pulse wins over the issue condition in the same cycle.
  assign issue_ok = (state_q == S_ISSUE) && !cfg_stop && !mem_rd_full &&
                    cal_done && (credits_q >= CRED_WPR) && bl_gap_ok;

  assign at_high    = (addr_cur_q == addr_high_q);
  assign iter_inc   = (iter_cnt_q == '1) ? iter_cnt_q : (iter_cnt_q + ITER_ONE);
  assign final_wrap = issue_ok && at_high && (iter_tgt_q != '0) && (iter_inc == iter_tgt_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset_any) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_start) begin
          state_d = cfg_bad ? S_DONE : S_WAIT_CAL;
        end
      end
      S_WAIT_CAL: begin
        if (cfg_stop) begin
          state_d = S_DRAIN;
        end else if (cal_done) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cfg_stop || final_wrap) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (credits_q == CRED_FULL) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values: config latch, address walk, credits
  always_comb begin
    addr_low_d  = addr_low_q;
    addr_high_d = addr_high_q;
    addr_cur_d  = addr_cur_q;
    iter_tgt_d  = iter_tgt_q;
    iter_cnt_d  = iter_cnt_q;
    err_d       = err_q;
    credits_d   = credits_q;
    mem_r_n_d   = 1'b1;
    mem_ad_d    = mem_ad_q;

    if (start_ok) begin
      addr_low_d  = cfg_addr_low;
      addr_high_d = cfg_addr_high;
      addr_cur_d  = cfg_addr_low;
      iter_tgt_d  = cfg_iterations;
      iter_cnt_d  = '0;
      err_d       = cfg_bad;
    end

    if (issue_ok) begin
      mem_r_n_d = 1'b0;
      mem_ad_d  = addr_cur_q;
      credits_d = credits_q - CRED_WPR;
      if (at_high) begin
        addr_cur_d = addr_low_q;
        iter_cnt_d = iter_inc;
      end else begin
        addr_cur_d = addr_cur_q + ADDR_STEP;
      end
    end

    // A pop with all credits home has no word behind it; never count past full.
    if (fifo_rd_en && (issue_ok || (credits_q != CRED_FULL))) begin
      credits_d = credits_d + CRED_ONE;
    end

    busy_d = (state_d == S_WAIT_CAL) || (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset_any) begin
      addr_low_q  <= '0;
      addr_high_q <= '0;
      addr_cur_q  <= '0;
      iter_tgt_q  <= '0;
      iter_cnt_q  <= '0;
      err_q       <= 1'b0;
      credits_q   <= CRED_FULL;
      mem_r_n_q   <= 1'b1;
      mem_ad_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      addr_low_q  <= addr_low_d;
      addr_high_q <= addr_high_d;
      addr_cur_q  <= addr_cur_d;
      iter_tgt_q  <= iter_tgt_d;
      iter_cnt_q  <= iter_cnt_d;
      err_q       <= err_d;
      credits_q   <= credits_d;
      mem_r_n_q   <= mem_r_n_d;
      mem_ad_q    <= mem_ad_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // A pop while every credit is home means the FIFO was popped while empty
  always_ff @(posedge clk) begin
    if (!reset_any && fifo_rd_en) begin
      assert (credits_q != CRED_FULL);
    end
  end

  assign mem_r_n         = mem_r_n_q;
  assign mem_ad_rd       = mem_ad_q;
  assign status_busy     = busy_q;
  assign status_done     = done_q;
  assign status_err      = err_q;
  assign status_iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_mem_replay_rd_scheduler.sv
// Directed bench for mem_replay_rd_scheduler: three instances (BL2/64, BL2/4,
// BL4/64) share configuration and memory-side inputs; each has its own start
// and FIFO pop. A small FIFO model pops only words that have been issued.
module tb_mem_replay_rd_scheduler;

  localparam int AW = 19;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst, sw_rst, cal_done, cfg_stop, mem_rd_full;
  logic [AW-1:0] cfg_lo, cfg_hi;
  logic [IW-1:0] cfg_it;
  logic [2:0]    start;
  logic [2:0]    pop = '0;
  logic [2:0]    r_n, busy, done, err;
  logic [AW-1:0] ad [3];
  logic [IW-1:0] itc [3];

  int n_cmp  = 0;
  int n_fail = 0;

  // FIFO model state per instance
  int wpr [3] = '{1, 1, 2};
  int issued [3] = '{0, 0, 0};
  int popped [3] = '{0, 0, 0};
  int rd_cnt [3] = '{0, 0, 0};
  int granted [3] = '{0, 0, 0};
  int used [3] = '{0, 0, 0};
  bit auto_pop [3] = '{0, 0, 0};
  bit blk_prev [3] = '{0, 0, 0};
  int viol = 0;

  always #5 clk = ~clk;

  mem_replay_rd_scheduler #(.MEM_ADDR_WIDTH(AW), .MEM_BURST_LENGTH(2), .FIFO_DEPTH(64), .ITER_WIDTH(IW)) u_dut0 (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_done), .cfg_start(start[0]), .cfg_stop(cfg_stop),
    .cfg_addr_low(cfg_lo), .cfg_addr_high(cfg_hi), .cfg_iterations(cfg_it), .mem_rd_full(mem_rd_full),
    .mem_r_n(r_n[0]), .mem_ad_rd(ad[0]), .fifo_rd_en(pop[0]), .status_busy(busy[0]), .status_done(done[0]),
    .status_err(err[0]), .status_iter_cnt(itc[0]));

  mem_replay_rd_scheduler #(.MEM_ADDR_WIDTH(AW), .MEM_BURST_LENGTH(2), .FIFO_DEPTH(4), .ITER_WIDTH(IW)) u_dut1 (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_done), .cfg_start(start[1]), .cfg_stop(cfg_stop),
    .cfg_addr_low(cfg_lo), .cfg_addr_high(cfg_hi), .cfg_iterations(cfg_it), .mem_rd_full(mem_rd_full),
    .mem_r_n(r_n[1]), .mem_ad_rd(ad[1]), .fifo_rd_en(pop[1]), .status_busy(busy[1]), .status_done(done[1]),
    .status_err(err[1]), .status_iter_cnt(itc[1]));

  mem_replay_rd_scheduler #(.MEM_ADDR_WIDTH(AW), .MEM_BURST_LENGTH(4), .FIFO_DEPTH(64), .ITER_WIDTH(IW)) u_dut2 (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_done), .cfg_start(start[2]), .cfg_stop(cfg_stop),
    .cfg_addr_low(cfg_lo), .cfg_addr_high(cfg_hi), .cfg_iterations(cfg_it), .mem_rd_full(mem_rd_full),
    .mem_r_n(r_n[2]), .mem_ad_rd(ad[2]), .fifo_rd_en(pop[2]), .status_busy(busy[2]), .status_done(done[2]),
    .status_err(err[2]), .status_iter_cnt(itc[2]));

  // FIFO model: count reads seen after each edge, flag reads issued while
  // blocked, and pop only words that were actually issued.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || sw_rst) begin
        issued[i]   = 0;
        popped[i]   = 0;
        pop[i]      = 1'b0;
        blk_prev[i] = 1'b0;
      end else begin
        if (!r_n[i]) begin
          rd_cnt[i]++;
          issued[i] += wpr[i];
          if (blk_prev[i]) viol++;
        end
        blk_prev[i] = mem_rd_full || !cal_done;
        if ((issued[i] > popped[i]) && (auto_pop[i] || (granted[i] > used[i]))) begin
          pop[i] = 1'b1;
          popped[i]++;
          if (!auto_pop[i]) used[i]++;
        end else begin
          pop[i] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [AW-1:0] lo, input logic [AW-1:0] hi, input logic [IW-1:0] it);
    cfg_lo = lo;
    cfg_hi = hi;
    cfg_it = it;
  endtask

  task automatic wait_done(input int i, input int lim, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < lim; c++) begin
      if (done[i]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (r_n[i] !== 1'b1) begin n_fail++; $display("FAIL rst_r_n[%0d]: got %b expected 1", i, r_n[i]); end
      n_cmp++; if (ad[i] !== '0) begin n_fail++; $display("FAIL rst_ad[%0d]: got %0h expected 0", i, ad[i]); end
      n_cmp++; if ({busy[i], done[i], err[i]} !== 3'b000) begin n_fail++; $display("FAIL rst_status[%0d]: got %b expected 000", i, {busy[i], done[i], err[i]}); end
      n_cmp++; if (itc[i] !== '0) begin n_fail++; $display("FAIL rst_iter[%0d]: got %0d expected 0", i, itc[i]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    bit ok;
    logic [AW-1:0] exp;
    set_cfg(19'h10, 19'h13, 16'd2);
    auto_pop[0] = 1'b1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n_cmp++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL sweep_busy_start: got %b expected 1", busy[0]); end
    tick();
    n_cmp++; if (r_n[0] !== 1'b1) begin n_fail++; $display("FAIL sweep_latency: r_n got %b expected 1", r_n[0]); end
    for (int k = 0; k < 8; k++) begin
      tick();
      exp = 19'h10 + AW'(k % 4);
      n_cmp++; if (r_n[0] !== 1'b0 || ad[0] !== exp) begin n_fail++; $display("FAIL sweep_rd%0d: r_n=%b ad=%0h expected r_n=0 ad=%0h", k, r_n[0], ad[0], exp); end
    end
    n_cmp++; if (itc[0] !== 16'd2) begin n_fail++; $display("FAIL sweep_iter: got %0d expected 2", itc[0]); end
    tick();
    n_cmp++; if (r_n[0] !== 1'b1) begin n_fail++; $display("FAIL sweep_no_extra: r_n got %b expected 1", r_n[0]); end
    wait_done(0, 50, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL sweep_done: timeout, done=%b expected 1", done[0]); end
    n_cmp++; if (busy[0] !== 1'b0 || err[0] !== 1'b0) begin n_fail++; $display("FAIL sweep_final: busy=%b err=%b expected 0 0", busy[0], err[0]); end
    auto_pop[0] = 1'b0;
  endtask

  task automatic test_credit_stall();
    bit ok;
    int b;
    int c;
    set_cfg(19'h100, 19'h1FF, 16'd0);
    b = rd_cnt[1];
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    repeat (20) tick();
    n_cmp++; if (rd_cnt[1] - b !== 4) begin n_fail++; $display("FAIL credit_stall_cnt: got %0d reads expected 4", rd_cnt[1] - b); end
    n_cmp++; if (r_n[1] !== 1'b1) begin n_fail++; $display("FAIL credit_stall_rn: got %b expected 1", r_n[1]); end
    granted[1] += 1;
    c = 0;
    while (r_n[1] !== 1'b0 && c < 10) begin tick(); c++; end
    n_cmp++; if (r_n[1] !== 1'b0 || ad[1] !== 19'h104) begin n_fail++; $display("FAIL credit_one_more: r_n=%b ad=%0h expected r_n=0 ad=104", r_n[1], ad[1]); end
    repeat (10) tick();
    n_cmp++; if (rd_cnt[1] - b !== 5) begin n_fail++; $display("FAIL credit_total: got %0d reads expected 5", rd_cnt[1] - b); end
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    auto_pop[1] = 1'b1;
    wait_done(1, 50, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL credit_drain_done: timeout, done=%b expected 1", done[1]); end
    auto_pop[1] = 1'b0;
  endtask

  task automatic test_bl4();
    bit ok;
    int b;
    set_cfg(19'h0, 19'h6, 16'd1);
    auto_pop[2] = 1'b1;
    b = rd_cnt[2];
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k % 2 == 0) begin
        n_cmp++; if (r_n[2] !== 1'b0 || ad[2] !== AW'(k)) begin n_fail++; $display("FAIL bl4_rd%0d: r_n=%b ad=%0h expected r_n=0 ad=%0h", k, r_n[2], ad[2], k); end
      end else begin
        n_cmp++; if (r_n[2] !== 1'b1) begin n_fail++; $display("FAIL bl4_gap%0d: r_n got %b expected 1", k, r_n[2]); end
      end
    end
    wait_done(2, 50, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bl4_done: timeout, done=%b expected 1", done[2]); end
    n_cmp++; if (itc[2] !== 16'd1 || rd_cnt[2] - b !== 4) begin n_fail++; $display("FAIL bl4_totals: iter=%0d reads=%0d expected 1 4", itc[2], rd_cnt[2] - b); end
    auto_pop[2] = 1'b0;
  endtask

  task automatic test_stop_drain();
    bit ok;
    int b;
    int n;
    set_cfg(19'h0, 19'hFF, 16'd0);
    b = rd_cnt[0];
    granted[0] += 7;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (r_n[0] === 1'b0) n++;
      if (n == 10) break;
    end
    n_cmp++; if (n !== 10) begin n_fail++; $display("FAIL stop_reach10: got %0d reads expected 10", n); end
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    n_cmp++; if (r_n[0] !== 1'b1) begin n_fail++; $display("FAIL stop_cycle_rn: got %b expected 1", r_n[0]); end
    repeat (10) tick();
    n_cmp++; if (rd_cnt[0] - b !== 10) begin n_fail++; $display("FAIL stop_no_more: got %0d reads expected 10", rd_cnt[0] - b); end
    n_cmp++; if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin n_fail++; $display("FAIL stop_drain_hold: busy=%b done=%b expected 1 0", busy[0], done[0]); end
    granted[0] += 3;
    wait_done(0, 30, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL stop_done: timeout, done=%b expected 1", done[0]); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL stop_busy_fall: got %b expected 0", busy[0]); end
  endtask

  task automatic test_cfg_err();
    int b;
    set_cfg(19'h20, 19'h1F, 16'd1);
    b = rd_cnt[0];
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n_cmp++; if ({done[0], err[0], busy[0]} !== 3'b110) begin n_fail++; $display("FAIL cfg_err_status: done/err/busy got %b expected 110", {done[0], err[0], busy[0]}); end
    repeat (4) tick();
    n_cmp++; if (rd_cnt[0] - b !== 0 || r_n[0] !== 1'b1) begin n_fail++; $display("FAIL cfg_err_noread: reads=%0d r_n=%b expected 0 1", rd_cnt[0] - b, r_n[0]); end
  endtask

  task automatic test_full_cal_swrst();
    bit ok;
    int b0;
    int b1;
    int v0;
    set_cfg(19'h0, 19'h3FF, 16'd0);
    auto_pop[0] = 1'b1;
    auto_pop[1] = 1'b0;
    v0 = viol;
    b0 = rd_cnt[0];
    start[0] = 1'b1;
    start[1] = 1'b1;
    tick();
    start = '0;
    n_cmp++; if (err[0] !== 1'b0 || busy[0] !== 1'b1) begin n_fail++; $display("FAIL restart_clears_err: err=%b busy=%b expected 0 1", err[0], busy[0]); end
    for (int k = 0; k < 40; k++) begin
      mem_rd_full = (k % 2 == 1);
      cal_done    = !(k >= 15 && k < 23);
      tick();
    end
    mem_rd_full = 1'b0;
    cal_done    = 1'b1;
    tick();
    n_cmp++; if (viol - v0 !== 0) begin n_fail++; $display("FAIL blocked_issue: got %0d reads while blocked expected 0", viol - v0); end
    n_cmp++; if (rd_cnt[0] - b0 <= 5) begin n_fail++; $display("FAIL toggled_progress: got %0d reads expected more than 5", rd_cnt[0] - b0); end
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    n_cmp++; if (r_n[0] !== 1'b1 || ad[0] !== '0) begin n_fail++; $display("FAIL swrst_port: r_n=%b ad=%0h expected 1 0", r_n[0], ad[0]); end
    n_cmp++; if ({busy[0], done[0], err[0]} !== 3'b000 || itc[0] !== '0) begin n_fail++; $display("FAIL swrst_status: bde=%b iter=%0d expected 000 0", {busy[0], done[0], err[0]}, itc[0]); end
    n_cmp++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL swrst_busy1: got %b expected 0", busy[1]); end
    auto_pop[0] = 1'b0;
    b1 = rd_cnt[1];
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    repeat (20) tick();
    n_cmp++; if (rd_cnt[1] - b1 !== 4) begin n_fail++; $display("FAIL swrst_credits: got %0d reads expected 4", rd_cnt[1] - b1); end
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    auto_pop[1] = 1'b1;
    wait_done(1, 50, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL swrst_drain_done: timeout, done=%b expected 1", done[1]); end
    auto_pop[1] = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    sw_rst      = 1'b0;
    cal_done    = 1'b1;
    cfg_stop    = 1'b0;
    mem_rd_full = 1'b0;
    start       = '0;
    set_cfg('0, '0, '0);
    test_reset();
    test_sweep();
    test_credit_stall();
    test_bl4();
    test_stop_drain();
    test_cfg_err();
    test_full_cal_swrst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
